// File: rtl/deser_pingpong_ctrl_if.sv
// deser_pingpong_ctrl_if
// Handshake and strobe bundle between the ping-pong deserializer controller
// and its environment (upstream word source, two deserialize banks, array-side
// consumer).
//   in_valid      upstream word present on the shared deserializer input bus
//   in_ready      controller accepts the offered word this cycle
//   read_enable_0 shift strobe to bank 0
//   read_enable_1 shift strobe to bank 1
//   out_valid     bank out_sel holds a complete vector
//   out_sel       bank presented to the consumer
//   out_ready     consumer releases the presented bank
//   fill_count    words accepted into the current write bank
//   banks_full    per-bank FULL flags (bit i = bank i)
// Modport master is the environment side; modport slave is the controller.
interface deser_pingpong_ctrl_if #(
  parameter int LENGTH = 8,
  parameter int CNT_W  = $clog2(LENGTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic             read_enable_0;
  logic             read_enable_1;
  logic             out_valid;
  logic             out_sel;
  logic             out_ready;
  logic [CNT_W-1:0] fill_count;
  logic [1:0]       banks_full;

  modport master (
    output in_valid, out_ready,
    input  in_ready, read_enable_0, read_enable_1, out_valid, out_sel,
           fill_count, banks_full
  );

  modport slave (
    input  in_valid, out_ready,
    output in_ready, read_enable_0, read_enable_1, out_valid, out_sel,
           fill_count, banks_full
  );
endinterface

// File: rtl/deser_pingpong_ctrl.sv
// deser_pingpong_ctrl
// Steers an upstream word stream alternately into two deserialize banks,
// counting LENGTH words per bank, and presents each completed bank to the
// consumer with valid/ready. A presented bank is frozen (no strobes) until the
// consumer releases it, so filling one bank overlaps consumption of the other.
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   flush synchronous abort: all banks EMPTY, pointers and count to 0
//   bus   deser_pingpong_ctrl_if.slave (handshakes, strobes, status)
module deser_pingpong_ctrl #(
  parameter int LENGTH = 8,
  parameter int CNT_W  = $clog2(LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  deser_pingpong_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  bank_state_e      bank_q [2];
  bank_state_e      bank_d [2];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       in_ready;
  logic       out_valid;
  logic       accept;
  logic       release_bank;
  logic       last_word;
  logic [1:0] strobe;
  logic [1:0] full_vec;

  // rst is folded in so no word is taken and nothing is presented while the
  // controller is being reset, independent of the register contents.
  assign in_ready     = (bank_q[wr_q] != BANK_FULL) && !flush && !rst;
  assign out_valid    = (bank_q[rd_q] == BANK_FULL) && !flush && !rst;
  assign accept       = bus.in_valid && in_ready;
  assign release_bank = out_valid && bus.out_ready;
  assign last_word    = (cnt_q == CNT_W'(LENGTH - 1));

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign strobe[gi]   = accept && (wr_q == 1'(gi));
    assign full_vec[gi] = (bank_q[gi] == BANK_FULL);
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_sel       = rd_q;
  assign bus.read_enable_0 = strobe[0];
  assign bus.read_enable_1 = strobe[1];
  assign bus.fill_count    = cnt_q;
  assign bus.banks_full    = full_vec;

  // Accept and release never touch the same bank: the write bank is never
  // FULL when accepting and the read bank is always FULL when releasing, so
  // both updates can be applied independently in one cycle.
  always_comb begin
    bank_d = bank_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (flush) begin
      bank_d = '{default: BANK_EMPTY};
      wr_d   = 1'b0;
      rd_d   = 1'b0;
      cnt_d  = '0;
    end else begin
      if (accept) begin
        if (last_word) begin
          bank_d[wr_q] = BANK_FULL;
          cnt_d        = '0;
          wr_d         = ~wr_q;
        end else begin
          bank_d[wr_q] = BANK_FILLING;
          cnt_d        = cnt_q + CNT_W'(1);
        end
      end
      if (release_bank) begin
        bank_d[rd_q] = BANK_EMPTY;
        rd_d         = ~rd_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '{default: BANK_EMPTY};
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      bank_q <= bank_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_deser_pingpong_ctrl.sv
module tb_deser_pingpong_ctrl;
  localparam int L = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush;
  logic flush1;

  deser_pingpong_ctrl_if #(.LENGTH(L)) if8 ();
  deser_pingpong_ctrl_if #(.LENGTH(1)) if1 ();

  deser_pingpong_ctrl #(.LENGTH(L)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .bus(if8)
  );
  deser_pingpong_ctrl #(.LENGTH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .bus(if1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: vectors completed and released since the last reset or
  // flush, words in the current partial vector, and the queue of words of
  // vectors that are complete but not yet consumed (oldest first).
  int completed;
  int released;
  int partial;
  int nw;
  int exp_q[$];
  int part_q[$];
  // Behaviour of the two deserialize banks: index 0 is the top slice.
  int bank_data[2][L];
  int obs_acc;
  int obs_rel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    completed = 0;
    released  = 0;
    partial   = 0;
    exp_q.delete();
    part_q.delete();
  endtask

  // One clock cycle on the LENGTH=8 instance: drive, check at negedge,
  // advance the model across the rising edge.
  task automatic step(input bit v, input bit ordy, input bit fl, input bit r);
    int  pending;
    int  wr;
    int  sel;
    bit  e_ir, e_acc, e_ov, ok;
    logic [1:0] bf;
    logic re0_s, re1_s;
    rst = r;
    flush = fl;
    if8.in_valid = v;
    if8.out_ready = ordy;
    @(negedge clk);
    pending = completed - released;
    e_ir  = !r && !fl && (pending < 2);
    e_acc = v && e_ir;
    e_ov  = !r && !fl && (pending > 0);
    wr    = completed % 2;
    sel   = released % 2;
    bf    = 2'b00;
    for (int k = released; k < completed; k++) bf[k % 2] = 1'b1;
    chk("in_ready", if8.in_ready, e_ir);
    chk("read_enable_0", if8.read_enable_0, e_acc && (wr == 0));
    chk("read_enable_1", if8.read_enable_1, e_acc && (wr == 1));
    chk("out_valid", if8.out_valid, e_ov);
    chk("out_sel", if8.out_sel, sel[0]);
    chk("fill_count", if8.fill_count, partial);
    chk("banks_full", if8.banks_full, bf);
    if (e_ov) begin
      ok = 1'b1;
      for (int j = 0; j < L; j++) if (bank_data[sel][j] != exp_q[j]) ok = 1'b0;
      chk("bank_data", ok, 1);
    end
    if (if8.read_enable_0 === 1'b1 || if8.read_enable_1 === 1'b1) obs_acc++;
    if (if8.out_valid === 1'b1 && ordy) obs_rel++;
    re0_s = if8.read_enable_0;
    re1_s = if8.read_enable_1;
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      if ((b == 0 && re0_s === 1'b1) || (b == 1 && re1_s === 1'b1)) begin
        for (int j = 0; j < L - 1; j++) bank_data[b][j] = bank_data[b][j + 1];
        bank_data[b][L - 1] = nw;
      end
    end
    if (r || fl) begin
      model_clear();
    end else begin
      if (e_acc) begin
        part_q.push_back(nw);
        partial++;
        nw++;
        if (partial == L) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          partial = 0;
          completed++;
        end
      end
      if (e_ov && ordy) begin
        $display("release: bank %0d vector %0d", sel, released);
        repeat (L) void'(exp_q.pop_front());
        released++;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    flush1 = 1'b0;
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b0;
    if1.in_valid = 1'b0;
    if1.out_ready = 1'b0;
    nw = 1;
    obs_acc = 0;
    obs_rel = 0;
    for (int b = 0; b < 2; b++) for (int j = 0; j < L; j++) bank_data[b][j] = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with a word offered that must not be taken.
    step(1, 0, 0, 1);
    if8.in_valid = 1'b0;
    rst = 1'b0;

    // LENGTH=1 instance: each word fills a bank.
    if1.in_valid = 1'b1;
    @(negedge clk);
    chk("l1_in_ready_a", if1.in_ready, 1);
    chk("l1_re0_a", if1.read_enable_0, 1);
    chk("l1_re1_a", if1.read_enable_1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1_re0_b", if1.read_enable_0, 0);
    chk("l1_re1_b", if1.read_enable_1, 1);
    chk("l1_banks_full_b", if1.banks_full, 2'b01);
    chk("l1_out_valid_b", if1.out_valid, 1);
    chk("l1_fill_count_b", if1.fill_count, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1_banks_full_c", if1.banks_full, 2'b11);
    chk("l1_in_ready_c", if1.in_ready, 0);
    chk("l1_re_c", {if1.read_enable_1, if1.read_enable_0}, 2'b00);
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    if1.out_ready = 1'b1;
    @(negedge clk);
    chk("l1_out_sel_d", if1.out_sel, 0);
    @(posedge clk); #1;
    if1.out_ready = 1'b0;
    @(negedge clk);
    chk("l1_banks_full_e", if1.banks_full, 2'b10);
    chk("l1_out_sel_e", if1.out_sel, 1);
    chk("l1_in_ready_e", if1.in_ready, 1);
    @(posedge clk); #1;

    // Basic fill of bank 0.
    repeat (8) step(1, 0, 0, 0);
    chk("bank0_top", bank_data[0][0], 1);
    chk("bank0_bottom", bank_data[0][L - 1], 8);
    // Ping-pong into bank 1, then backpressure.
    repeat (9) step(1, 0, 0, 0);
    chk("bank0_frozen", bank_data[0][0], 1);
    // Release pulse, then word 17 goes to bank 0.
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("word17_bank0", bank_data[0][L - 1], 17);

    // Streaming with consumer always ready.
    step(0, 0, 0, 1);
    obs_acc = 0;
    obs_rel = 0;
    repeat (64) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("stream_accepts", obs_acc, 64);
    chk("stream_releases", obs_rel, 8);

    // Flush mid-fill with bank 0 full and 5 words in bank 1.
    step(0, 0, 0, 1);
    repeat (13) step(1, 0, 0, 0);
    chk("pre_flush_fill", if8.fill_count, 5);
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    repeat (8) step(1, 0, 0, 0);
    chk("post_flush_valid", if8.out_valid, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      step(($urandom % 4) != 0, ($urandom % 3) == 0,
           ($urandom % 60) == 0, ($urandom % 250) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/deser_pingpong_ctrl.md
# deser_pingpong_ctrl

Sequencing controller for the two `deserialize` shift-register banks that feed one systolic-array input edge. It steers an upstream word stream into the banks alternately (ping-pong) by driving their `read_enable` strobes, and counts exactly LENGTH words per bank. It presents a completed bank to the array-side consumer with a valid/ready handshake and freezes that bank until the consumer releases it, so loading the next vector overlaps consumption of the current one.

## Interface
- LENGTH, 8, words per vector; must equal the `deserialize` LENGTH; legal range ≥1.
- CNT_W, $clog2(LENGTH+1), width of the fill counter.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort; discards all bank contents (state only).
- in_valid  input  1  upstream word present on the shared deserializer `in` bus.
- in_ready  output  1  controller will accept the word this cycle.
- read_enable_0  output  1  shift strobe to bank 0 `deserialize`.
- read_enable_1  output  1  shift strobe to bank 1 `deserialize`.
- out_valid  output  1  bank `out_sel` holds a complete LENGTH-word vector.
- out_sel  output  1  index of the bank presented to the consumer.
- out_ready  input  1  consumer has taken the vector; releases the bank.
- fill_count  output  CNT_W  words accepted into the current write bank, 0..LENGTH-1.
- banks_full  output  2  per-bank FULL flags (bit i = bank i).

## Operation
- Each bank has state EMPTY, FILLING or FULL. Pointers: wr_bank and rd_bank, 1 bit each.
- in_ready = (bank[wr_bank] != FULL) and not flush.
- accept = in_valid & in_ready.
- read_enable_i = accept & (wr_bank == i). This is combinational, and at most one strobe is high per cycle. A FULL bank never receives a strobe, so its contents stay frozen.
- On accept:
  - The bank goes EMPTY→FILLING on its first word.
  - If fill_count == LENGTH-1: the bank goes FULL, fill_count returns to 0, and wr_bank toggles.
  - Otherwise fill_count increments.
  - For LENGTH=1, every accept fills a bank.
- out_valid = (bank[rd_bank] == FULL) and not flush. out_sel = rd_bank.
- Release = out_valid & out_ready. bank[rd_bank] goes to EMPTY and rd_bank toggles. out_ready without out_valid is ignored.
- Simultaneous accept and release always target different banks and both take effect. The wr bank cannot be FULL while accepting, and rd points only at a FULL bank. There is no same-cycle bypass: a bank released in cycle t gives in_ready=1 for it from cycle t+1 only.
- Data ordering (a property of `deserialize`): the first accepted word of a vector ends in the top slice of the bank output, and the LENGTH-th word ends in the bottom slice.
- Bank data registers are never cleared. Correctness relies solely on out_valid asserting only after exactly LENGTH strobes since the bank was last EMPTY.
- flush, and likewise rst, has priority over accept and release in the same cycle:
  - all banks go EMPTY, both pointers go to 0, fill_count goes to 0;
  - strobes are 0 that cycle;
  - a word offered that cycle is not accepted.

## Timing
- Reset values: in_ready=1 from the cycle after rst, and 0 while rst is high. read_enable_0/1=0, out_valid=0, out_sel=0, fill_count=0, banks_full=2'b00.
- Latency: the LENGTH-th word accepted in cycle t gives out_valid=1 in cycle t+1, the cycle when the bank data is settled.
- Throughput: with out_ready tied high, one word is accepted every cycle indefinitely, and one vector is released every LENGTH cycles.
- Backpressure: when both banks are FULL, in_ready=0 until a release.
- out_valid stays high and out_sel stays stable until a release. The consumer may hold out_ready low for any number of cycles.
- Reset or flush mid-fill or mid-hold takes effect at the next edge, with no partial vector ever presented afterwards.

## Test plan
- **Basic fill.** LENGTH=8, rst then in_valid=1 for 8 cycles with words 1..8, out_ready=0.
  - Expect read_enable_0 high for 8 cycles, then out_valid=1, out_sel=0, banks_full=01.
  - Bank 0 top slice = 1, bottom slice = 8.
- **Ping-pong backpressure.** Continue in_valid=1 with out_ready=0.
  - Words 9..16 strobe bank 1 only, then banks_full=11 and in_ready=0.
  - Bank 0 contents stay unchanged throughout.
- **Release and refill overlap.** From both banks full, pulse out_ready for 1 cycle.
  - out_sel changes 0→1 and banks_full=10.
  - in_ready rises the next cycle, and word 17 strobes bank 0.
- **Streaming.** out_ready=1, in_valid=1 for 64 cycles.
  - Expect 64 accepts with no bubble and 8 releases alternating out_sel 0,1,0,…
  - First out_valid at cycle 9.
- **Flush mid-fill.** After 5 words into bank 1 with bank 0 FULL, assert flush with in_valid=1 and out_ready=1.
  - No strobe and no release that cycle.
  - Next cycle: banks_full=00, fill_count=0, out_sel=0.
  - A fresh 8 words then produce out_valid.
- **Boundary LENGTH=1.** Each accepted word sets FULL and toggles wr_bank. Two words with out_ready=0 give banks_full=11 and in_ready=0.
